// File: rtl/lfsr_rng_pkg.sv
// Shared definitions for the LFSR-backed random-number arbiter.
package lfsr_rng_pkg;

    localparam int unsigned LFSR_W = 3;
    localparam int unsigned REQ_N  = 2;

    localparam logic [LFSR_W-1:0] SEED_RST_DEF = 3'b001;
    localparam logic [LFSR_W-1:0] LOCKUP_SUB   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Fibonacci step: period 7 over the non-zero states.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[1:0], cur[2] ^ cur[1]};
    endfunction

endpackage

// File: rtl/lfsr3_core.sv
// 3-bit Fibonacci LFSR with synchronous load and single-step advance.
module lfsr3_core
    import lfsr_rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_RST = SEED_RST_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    // All-zero would lock the register, so it is replaced on load.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            q <= SEED_RST;
        end else if (load) begin
            q <= (load_val == '0) ? LOCKUP_SUB : load_val;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/lfsr_rng_arb.sv
// Two-requester round-robin arbiter handing out one LFSR value per grant.
module lfsr_rng_arb
    import lfsr_rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_RST = SEED_RST_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [REQ_N-1:0]  req,
    input  logic              seed_we,
    input  logic [LFSR_W-1:0] seed,
    output logic [REQ_N-1:0]  ack,
    output logic [LFSR_W-1:0] rnd_data,
    output logic              busy
);

    state_e            state;
    logic              grant_idx;
    logic              last_srv;
    logic [LFSR_W-1:0] lfsr_q;
    logic              lfsr_load_c;
    logic              lfsr_step_c;
    logic              rr_pick_c;

    // Seeding only accepted while idle; stepping only in STEP.
    assign lfsr_load_c = (state == ST_IDLE) && seed_we;
    assign lfsr_step_c = (state == ST_STEP);

    // With both requesting, the one not served last wins.
    assign rr_pick_c = (req == 2'b11) ? ~last_srv : req[1];

    lfsr3_core #(
        .SEED_RST (SEED_RST)
    ) u_core (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (lfsr_load_c),
        .load_val (seed),
        .step     (lfsr_step_c),
        .q        (lfsr_q)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            grant_idx <= 1'b0;
            last_srv  <= 1'b1;
            ack       <= '0;
            rnd_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= '0;
                    if (!seed_we && (req != '0)) begin
                        grant_idx <= rr_pick_c;
                        busy      <= 1'b1;
                        state     <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    // Publish the post-step value together with the ack.
                    ack      <= REQ_N'(1) << grant_idx;
                    rnd_data <= lfsr_next(lfsr_q);
                    state    <= ST_ACK;
                end
                ST_ACK: begin
                    ack      <= '0;
                    last_srv <= grant_idx;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng_arb.sv
// Scoreboard bench for lfsr_rng_arb: directed grants with hand-computed results.
module tb_lfsr_rng_arb;

    logic       sys_clk;
    logic       sys_rst;
    logic [1:0] req;
    logic       seed_we;
    logic [2:0] seed;
    logic [1:0] ack;
    logic [2:0] rnd_data;
    logic       busy;

    typedef struct {
        logic [1:0]  ack;
        logic [2:0]  rnd;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          n_checks;
    int          n_fail;
    logic [1:0]  prev_ack;

    lfsr_rng_arb #(.SEED_RST(3'b001)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req      (req),
        .seed_we  (seed_we),
        .seed     (seed),
        .ack      (ack),
        .rnd_data (rnd_data),
        .busy     (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [1:0] a, input logic [2:0] r, input int unsigned when);
        exp_t e;
        e.ack = a;
        e.rnd = r;
        e.cyc = when;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    // Single grant: req sampled on the next edge, ack two edges later.
    task automatic grant(input logic [1:0] r, input logic [1:0] exp_ack, input logic [2:0] exp_rnd);
        req = r;
        push(exp_ack, exp_rnd, cyc + 2);
        tick();
        chk("busy_step", 32'(busy), 32'd1);
        tick();
        chk("busy_ack", 32'(busy), 32'd1);
        req = 2'b00;
        tick();
        chk("busy_idle", 32'(busy), 32'd0);
        chk("rnd_hold", 32'(rnd_data), 32'(exp_rnd));
    endtask

    // Monitor: every non-zero ack must match the head of the scoreboard.
    always @(negedge sys_clk) begin
        if (ack !== 2'b00) begin
            chk("ack_gap", 32'(prev_ack), 32'd0);
            if (sb.size() == 0) begin
                n_checks = n_checks + 1;
                n_fail   = n_fail + 1;
                $display("FAIL unexpected_ack: got ack=%b rnd=%b with nothing expected (cycle %0d)",
                         ack, rnd_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_val", 32'(ack), 32'(e.ack));
                chk("rnd_val", 32'(rnd_data), 32'(e.rnd));
                chk("ack_cycle", cyc, e.cyc);
            end
        end
        prev_ack <= ack;
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_ack = 2'b00;
        sys_rst  = 1'b1;
        req      = 2'b00;
        seed_we  = 1'b0;
        seed     = 3'b000;

        // Reset state
        do_reset();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rnd", 32'(rnd_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single requester from reset
        grant(2'b01, 2'b01, 3'b010);

        // Both requesting: alternating, every 3 cycles
        do_reset();
        req = 2'b11;
        push(2'b01, 3'b010, cyc + 2);
        push(2'b10, 3'b101, cyc + 5);
        push(2'b01, 3'b011, cyc + 8);
        push(2'b10, 3'b111, cyc + 11);
        repeat (11) tick();
        req = 2'b00;
        tick();
        chk("busy_after_rr", 32'(busy), 32'd0);

        // Seeding in IDLE, including the lock-up substitute
        do_reset();
        seed_we = 1'b1;
        seed    = 3'b110;
        tick();
        seed_we = 1'b0;
        grant(2'b10, 2'b10, 3'b100);
        seed_we = 1'b1;
        seed    = 3'b000;
        tick();
        seed_we = 1'b0;
        grant(2'b01, 2'b01, 3'b010);

        // Seed and request together: seed first, ack one cycle later
        do_reset();
        seed_we = 1'b1;
        seed    = 3'b011;
        req     = 2'b01;
        push(2'b01, 3'b111, cyc + 3);
        tick();
        seed_we = 1'b0;
        chk("busy_seed_prio", 32'(busy), 32'd0);
        tick();
        tick();
        req = 2'b00;
        tick();
        chk("rnd_seed_prio", 32'(rnd_data), 32'd7);

        // Seed during STEP ignored; seven grants wrap to 001
        do_reset();
        req = 2'b01;
        push(2'b01, 3'b010, cyc + 2);
        tick();
        seed_we = 1'b1;
        seed    = 3'b110;
        tick();
        seed_we = 1'b0;
        req     = 2'b00;
        tick();
        grant(2'b01, 2'b01, 3'b101);
        grant(2'b01, 2'b01, 3'b011);
        grant(2'b01, 2'b01, 3'b111);
        grant(2'b01, 2'b01, 3'b110);
        grant(2'b01, 2'b01, 3'b100);
        grant(2'b01, 2'b01, 3'b001);

        // Reset in STEP aborts the grant
        do_reset();
        req = 2'b01;
        tick();
        chk("busy_before_abort", 32'(busy), 32'd1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        req     = 2'b00;
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        tick();
        chk("abort_ack_late", 32'(ack), 32'd0);
        grant(2'b01, 2'b01, 3'b010);

        // Reset beats seed_we and req in the same cycle
        sys_rst = 1'b1;
        seed_we = 1'b1;
        seed    = 3'b110;
        req     = 2'b11;
        tick();
        sys_rst = 1'b0;
        seed_we = 1'b0;
        req     = 2'b00;
        chk("rst_prio_busy", 32'(busy), 32'd0);
        grant(2'b01, 2'b01, 3'b010);

        repeat (4) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
